// File: rtl/inst_fetch_unit.sv
// Instruction-fetch stage: generates the fetch PC, reads aligned instruction
// pairs from the local store, buffers them in a prefetch queue and presents
// one pair per cycle to the IF/ID register. Handles stall and branch redirect.
module inst_fetch_unit #(
  parameter int unsigned FQ_DEPTH = 4,
  parameter logic [0:31] RESET_PC = 32'h0000_0000,
  parameter logic [0:31] NOP_INST = 32'h4020_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [0:12] stall,
  input  logic        br_flag,
  input  logic [0:31] br_target,
  output logic        ls_req,
  output logic [0:31] ls_addr,
  input  logic        ls_gnt,
  input  logic        ls_rvalid,
  input  logic [0:63] ls_rdata,
  output logic [0:31] if_pc,
  output logic [0:63] if_inst,
  output logic        if_valid,
  output logic [0:3]  fq_count
);

  localparam int unsigned PW      = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam logic [3:0]  DEPTH_C = 4'(FQ_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DISCARD} state_e;

  state_e          state_q, state_d;
  logic [0:31]     fetch_pc_q, fetch_pc_d;
  logic [0:31]     rd_addr_q, rd_addr_d;
  logic            odd_q, odd_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [3:0]      count_q, count_d;
  logic [0:31]     if_pc_q, if_pc_d;
  logic [0:63]     if_inst_q, if_inst_d;
  logic            if_valid_q, if_valid_d;

  logic [0:31]     fq_pc_mem   [FQ_DEPTH];
  logic [0:63]     fq_inst_mem [FQ_DEPTH];

  logic            enq, pop, space, gnt_take;
  logic [3:0]      count_after;
  logic [0:63]     enq_inst;

  // Only the first stall bit belongs to this stage.
  logic            unused_stall;
  assign unused_stall = ^stall[1:12];

  // Next-state logic for the queue, output stage, request FSM and fetch PC.
  // NOTE: every variable gets a default at the top so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    rd_addr_d  = rd_addr_q;
    odd_d      = odd_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
    if_valid_d = if_valid_q;

    // A redirect kills both the pop and any returning data this cycle.
    pop         = !br_flag && !stall[0] && (count_q != '0);
    enq         = !br_flag && (state_q == S_WAIT) && ls_rvalid;
    count_after = count_q + {3'b000, enq} - {3'b000, pop};
    space       = count_after < DEPTH_C;

    // Back-to-back request when data returns keeps one pair per cycle flowing.
    ls_req   = (state_q == S_REQ) ||
               ((state_q == S_WAIT) && ls_rvalid && space && !br_flag);
    ls_addr  = ls_req ? fetch_pc_q : '0;
    gnt_take = ls_req && ls_gnt;

    enq_inst = ls_rdata;
    if (odd_q) enq_inst[0:31] = NOP_INST;

    // Output stage and queue pointers.
    if (br_flag) begin
      if_pc_d    = '0;
      if_inst_d  = '0;
      if_valid_d = 1'b0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      odd_d      = br_target[29];
    end else begin
      if (!stall[0]) begin
        if (pop) begin
          if_pc_d    = fq_pc_mem[rd_ptr_q];
          if_inst_d  = fq_inst_mem[rd_ptr_q];
          if_valid_d = 1'b1;
        end else begin
          if_pc_d    = '0;
          if_inst_d  = '0;
          if_valid_d = 1'b0;
        end
      end
      if (enq) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        odd_d    = 1'b0;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_after;
    end

    // Request FSM. A slot is reserved at grant, so IDLE only needs the count.
    case (state_q)
      S_IDLE:    if (count_q < DEPTH_C) state_d = S_REQ;
      S_REQ:     if (gnt_take) state_d = S_WAIT;
      S_WAIT:    if (ls_rvalid) state_d = !space ? S_IDLE : (gnt_take ? S_WAIT : S_REQ);
      S_DISCARD: if (ls_rvalid) state_d = S_REQ;
      default:   state_d = S_IDLE;
    endcase

    if (gnt_take) begin
      fetch_pc_d = fetch_pc_q + 32'd8;
      rd_addr_d  = fetch_pc_q;
    end

    // Redirect overrides the fetch PC; a read still in flight must be drained.
    if (br_flag) begin
      fetch_pc_d = {br_target[0:28], 3'b000};
      case (state_q)
        S_IDLE, S_REQ: state_d = gnt_take ? S_DISCARD : S_REQ;
        S_WAIT:        state_d = ls_rvalid ? S_REQ : S_DISCARD;
        default:       ;
      endcase
    end
  end

  // State registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= {RESET_PC[0:28], 3'b000};
      rd_addr_q  <= '0;
      odd_q      <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      if_pc_q    <= '0;
      if_inst_q  <= '0;
      if_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rd_addr_q  <= rd_addr_d;
      odd_q      <= odd_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
      if_valid_q <= if_valid_d;
    end
  end

  // Queue storage write port.
  // NOTE: the storage array is not reset; the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (enq) begin
      fq_pc_mem[wr_ptr_q]   <= rd_addr_q;
      fq_inst_mem[wr_ptr_q] <= enq_inst;
    end
  end

  assign if_pc    = if_pc_q;
  assign if_inst  = if_inst_q;
  assign if_valid = if_valid_q;
  assign fq_count = count_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a single-outstanding local-store
// model whose read data is the address pattern {addr, addr+4}.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [0:12] stall;
  logic        br_flag;
  logic [0:31] br_target;
  logic        ls_req;
  logic [0:31] ls_addr;
  logic        ls_gnt;
  logic        ls_rvalid;
  logic [0:63] ls_rdata;
  logic [0:31] if_pc;
  logic [0:63] if_inst;
  logic        if_valid;
  logic [0:3]  fq_count;

  // Memory model state
  logic        gnt_en;
  int          mem_lat;
  int          gnt_cnt = 0;
  logic        pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;
  logic [31:0] exp_gnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  inst_fetch_unit dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .br_flag   (br_flag),
    .br_target (br_target),
    .ls_req    (ls_req),
    .ls_addr   (ls_addr),
    .ls_gnt    (ls_gnt),
    .ls_rvalid (ls_rvalid),
    .ls_rdata  (ls_rdata),
    .if_pc     (if_pc),
    .if_inst   (if_inst),
    .if_valid  (if_valid),
    .fq_count  (fq_count)
  );

  assign ls_gnt = ls_req & gnt_en & ~rst;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [63:0] pair(input logic [31:0] a);
    return {a, a + 32'd4};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max, input string tag);
    for (int i = 0; i < max && !if_valid; i++) step();
    check(tag, if_valid, 1'b1);
  endtask

  // Grant side: check each granted address against the expected fetch stream.
  always @(posedge clk) begin
    if (ls_req && ls_gnt) begin
      check("gnt_addr", ls_addr, exp_gnt);
      exp_gnt   = exp_gnt + 32'd8;
      pend      = 1'b1;
      pend_addr = ls_addr;
      pend_cnt  = mem_lat;
      gnt_cnt++;
    end
  end

  // Data side: return the pair mem_lat cycles after the grant.
  always @(negedge clk) begin
    ls_rvalid = 1'b0;
    ls_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        ls_rvalid = 1'b1;
        ls_rdata  = pair(pend_addr);
        pend      = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_pc;
    int          saved;

    rst = 1'b1; stall = '0; br_flag = 1'b0; br_target = '0;
    gnt_en = 1'b1; mem_lat = 1; exp_gnt = 32'h0;
    repeat (3) step();

    // Reset state
    check("rst_if_pc", if_pc, 0);
    check("rst_if_inst", if_inst, 0);
    check("rst_if_valid", if_valid, 0);
    check("rst_ls_req", ls_req, 0);
    check("rst_ls_addr", ls_addr, 0);
    check("rst_fq_count", fq_count, 0);
    rst = 1'b0;

    // Streaming with 1-cycle memory: one pair per cycle, in order
    wait_valid(20, "t1_first_valid");
    exp_pc = 32'h0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        step();
        exp_pc = exp_pc + 32'd8;
      end
      check("t1_valid", if_valid, 1'b1);
      check("t1_pc", if_pc, exp_pc);
      check("t1_inst", if_inst, pair(exp_pc));
    end

    // Stall: outputs frozen, queue fills to depth, requests stop
    stall[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("t2_hold_pc", if_pc, exp_pc);
      check("t2_hold_valid", if_valid, 1'b1);
    end
    check("t2_fq_full", fq_count, 4);
    check("t2_no_req", ls_req, 0);
    stall[0] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      exp_pc = exp_pc + 32'd8;
      step();
      wait_valid(10, "t2_resume_valid");
      check("t2_resume_pc", if_pc, exp_pc);
      check("t2_resume_inst", if_inst, pair(exp_pc));
    end

    // Redirect to odd-word target while a 3-cycle read is outstanding
    mem_lat = 3;
    saved = gnt_cnt;
    for (int i = 0; i < 10 && gnt_cnt == saved; i++) step();
    check("t3_gnt_seen", gnt_cnt != saved, 1'b1);
    br_target = 32'h0000_0104;
    br_flag   = 1'b1;
    step();
    br_flag = 1'b0;
    exp_gnt = 32'h0000_0100;
    check("t3_flush_valid", if_valid, 0);
    check("t3_flush_pc", if_pc, 0);
    check("t3_flush_inst", if_inst, 0);
    check("t3_flush_count", fq_count, 0);
    wait_valid(30, "t3_valid");
    check("t3_pc", if_pc, 32'h0000_0100);
    check("t3_inst_nop", if_inst, 64'h4020_0000_0000_0104);
    step();
    wait_valid(10, "t3_next_valid");
    check("t3_next_pc", if_pc, 32'h0000_0108);
    check("t3_next_inst", if_inst, pair(32'h0000_0108));

    // Redirect coinciding with a grant while stalled
    stall[0] = 1'b1;
    gnt_en   = 1'b0;
    repeat (8) step();
    check("t4_held_valid", if_valid, 1'b1);
    check("t4_req_pending", ls_req, 1'b1);
    check("t4_req_addr", ls_addr, exp_gnt);
    br_target = 32'h0000_0200;
    br_flag   = 1'b1;
    gnt_en    = 1'b1;
    step();
    br_flag = 1'b0;
    exp_gnt = 32'h0000_0200;
    check("t4_clear_valid", if_valid, 0);
    check("t4_clear_pc", if_pc, 0);
    check("t4_clear_inst", if_inst, 0);
    check("t4_clear_count", fq_count, 0);
    repeat (3) step();
    stall[0] = 1'b0;
    wait_valid(30, "t4_valid");
    check("t4_pc", if_pc, 32'h0000_0200);
    check("t4_inst", if_inst, pair(32'h0000_0200));

    // Fetch PC wrap at the top of the address space
    mem_lat   = 1;
    br_target = 32'hFFFF_FFF0;
    br_flag   = 1'b1;
    step();
    br_flag = 1'b0;
    exp_gnt = 32'hFFFF_FFF0;
    exp_pc  = 32'hFFFF_FFF0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      wait_valid(20, "t5_wrap_valid");
      check("t5_wrap_pc", if_pc, exp_pc);
      check("t5_wrap_inst", if_inst, pair(exp_pc));
      exp_pc = exp_pc + 32'd8;
    end

    // Reset while a read is outstanding; the late data must be ignored
    mem_lat = 3;
    saved = gnt_cnt;
    for (int i = 0; i < 10 && gnt_cnt == saved; i++) step();
    check("t6_gnt_seen", gnt_cnt != saved, 1'b1);
    rst = 1'b1;
    step();
    check("t6_rst_if_pc", if_pc, 0);
    check("t6_rst_if_inst", if_inst, 0);
    check("t6_rst_if_valid", if_valid, 0);
    check("t6_rst_ls_req", ls_req, 0);
    check("t6_rst_ls_addr", ls_addr, 0);
    check("t6_rst_fq_count", fq_count, 0);
    rst     = 1'b0;
    exp_gnt = 32'h0;
    wait_valid(40, "t6_valid");
    check("t6_pc", if_pc, 32'h0);
    check("t6_inst", if_inst, pair(32'h0));
    step();
    wait_valid(10, "t6_next_valid");
    check("t6_next_pc", if_pc, 32'h8);
    check("t6_next_inst", if_inst, pair(32'h8));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
